// File: rtl/weight_update_sequencer_if.sv
// Handshake/bus bundle between the weight update sequencer, its controller,
// the gradient stack and the dense-layer weight memory.
interface weight_update_sequencer_if #(
  parameter int data_size = 16,
  parameter int size      = 3
);
  logic                        start;
  logic [31:0]                 num_layers;
  logic [data_size-1:0]        learning_rate;
  logic                        busy;
  logic                        done;
  logic                        cal_dc_dw;
  logic [31:0]                 dc_dw_layer;
  logic [31:0]                 dc_dw_row;
  logic [data_size*size-1:0]   dc_dw_stream;
  logic                        w_rd_en;
  logic [31:0]                 w_layer;
  logic [31:0]                 w_row;
  logic [data_size*size-1:0]   w_rd_data;
  logic                        w_wr_en;
  logic [data_size*size-1:0]   w_wr_data;

  modport master (
    input  start, num_layers, learning_rate, dc_dw_stream, w_rd_data,
    output busy, done, cal_dc_dw, dc_dw_layer, dc_dw_row,
           w_rd_en, w_layer, w_row, w_wr_en, w_wr_data
  );

  modport slave (
    output start, num_layers, learning_rate, dc_dw_stream, w_rd_data,
    input  busy, done, cal_dc_dw, dc_dw_layer, dc_dw_row,
           w_rd_en, w_layer, w_row, w_wr_en, w_wr_data
  );
endinterface

// File: rtl/weight_update_sequencer.sv
// Walks every (layer,row), fetches gradient and weight rows, and writes back
// w - sat((lr*grad) >>> frac_bits), saturated per lane.
module wus_lane #(
  parameter int DW = 16,
  parameter int FB = 8
) (
  input  logic signed [DW-1:0] lr,
  input  logic signed [DW-1:0] grad,
  input  logic signed [DW-1:0] w,
  output logic signed [DW-1:0] w_new
);
  logic signed [2*DW-1:0] prod, sh;
  logic signed [DW-1:0]   delta;
  logic signed [DW:0]     diff;

  always_comb begin
    prod = lr * grad;
    sh   = prod >>> FB;
    // the shifted product fits in DW bits only if its top DW+1 bits agree
    if (&sh[2*DW-1:DW-1] || ~|sh[2*DW-1:DW-1]) delta = sh[DW-1:0];
    else delta = sh[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    diff = {w[DW-1], w} - {delta[DW-1], delta};
    if (diff[DW] == diff[DW-1]) w_new = diff[DW-1:0];
    else w_new = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
endmodule

module weight_update_sequencer #(
  parameter int data_size      = 16,
  parameter int size           = 3,
  parameter int max_layer_size = 4,
  parameter int frac_bits      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  weight_update_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, CAPTURE, WRITE, DONE} state_t;

  state_t                           state_q, state_d;
  logic [31:0]                      layer_q, layer_d, row_q, row_d;
  logic [31:0]                      nl_q, nl_d, nl_clamp;
  logic [31:0]                      addr_layer_q, addr_layer_d, addr_row_q, addr_row_d;
  logic [data_size-1:0]             lr_q, lr_d;
  logic [size-1:0][data_size-1:0]   grad_q, grad_d, wt_q, wt_d, new_row;

  assign nl_clamp = (bus.num_layers > 32'(max_layer_size)) ? 32'(max_layer_size)
                                                           : bus.num_layers;

  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    row_d        = row_q;
    nl_d         = nl_q;
    lr_d         = lr_q;
    grad_d       = grad_q;
    wt_d         = wt_q;
    addr_layer_d = addr_layer_q;
    addr_row_d   = addr_row_q;
    case (state_q)
      IDLE: if (bus.start) begin
        lr_d    = bus.learning_rate;
        nl_d    = nl_clamp;
        layer_d = '0;
        row_d   = '0;
        state_d = (nl_clamp == '0) ? DONE : REQ;
      end
      REQ:     state_d = CAPTURE;
      CAPTURE: begin
        grad_d  = bus.dc_dw_stream;
        wt_d    = bus.w_rd_data;
        state_d = WRITE;
      end
      WRITE: begin
        if (row_q == 32'(size - 1)) begin
          row_d   = '0;
          layer_d = layer_q + 32'd1;
          state_d = (layer_q == nl_q - 32'd1) ? DONE : REQ;
        end else begin
          row_d   = row_q + 32'd1;
          state_d = REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // addresses latch on entry to REQ and hold through WRITE and beyond
    if (state_d == REQ) begin
      addr_layer_d = layer_d;
      addr_row_d   = row_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      layer_q      <= '0;
      row_q        <= '0;
      nl_q         <= '0;
      lr_q         <= '0;
      grad_q       <= '0;
      wt_q         <= '0;
      addr_layer_q <= '0;
      addr_row_q   <= '0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      row_q        <= row_d;
      nl_q         <= nl_d;
      lr_q         <= lr_d;
      grad_q       <= grad_d;
      wt_q         <= wt_d;
      addr_layer_q <= addr_layer_d;
      addr_row_q   <= addr_row_d;
    end
  end

  for (genvar i = 0; i < size; i++) begin : g_lane
    wus_lane #(.DW(data_size), .FB(frac_bits)) u_lane (
      .lr    (lr_q),
      .grad  (grad_q[i]),
      .w     (wt_q[i]),
      .w_new (new_row[i])
    );
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.cal_dc_dw   = (state_q == REQ);
  assign bus.w_rd_en     = (state_q == REQ);
  assign bus.w_wr_en     = (state_q == WRITE);
  assign bus.dc_dw_layer = addr_layer_q;
  assign bus.dc_dw_row   = addr_row_q;
  assign bus.w_layer     = addr_layer_q;
  assign bus.w_row       = addr_row_q;
  assign bus.w_wr_data   = new_row;
endmodule

// File: tb/tb_weight_update_sequencer.sv
// Bench for weight_update_sequencer: table vectors, directed corner cases and
// randomized passes checked against a plain-arithmetic reference model.
module tb_weight_update_sequencer;
  logic clk = 0;
  logic reset = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   n_pass = 0, n_total = 0;

  weight_update_sequencer_if #(.data_size(16), .size(3)) bus ();

  weight_update_sequencer #(
    .data_size(16), .size(3), .max_layer_size(4), .frac_bits(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // gradient stack and weight memory: registered replies, zero when not asked
  logic [47:0] gmem [0:3][0:3];
  logic [47:0] wmem [0:3][0:3];
  logic [47:0] wm0  [0:3][0:3];

  always @(posedge clk) begin
    bus.dc_dw_stream <= bus.cal_dc_dw ? gmem[bus.dc_dw_layer[1:0]][bus.dc_dw_row[1:0]] : '0;
    bus.w_rd_data    <= bus.w_rd_en   ? wmem[bus.w_layer[1:0]][bus.w_row[1:0]]         : '0;
  end

  typedef struct { int rel; logic [31:0] l, r, wl, wr; logic cal, rd; } req_t;
  typedef struct { int rel; logic [31:0] l, r; logic [47:0] data; } wr_t;
  req_t req_q[$];
  wr_t  wr_q[$];
  int   done_cnt, done_rel, busy_cnt, busy_last;
  logic mon_en = 0;

  always @(negedge clk) if (mon_en) begin
    int rel;
    rel = cyc - t0 + 1;
    if (bus.cal_dc_dw || bus.w_rd_en)
      req_q.push_back('{rel, bus.dc_dw_layer, bus.dc_dw_row, bus.w_layer, bus.w_row,
                        bus.cal_dc_dw, bus.w_rd_en});
    if (bus.w_wr_en) wr_q.push_back('{rel, bus.w_layer, bus.w_row, bus.w_wr_data});
    if (bus.done) begin done_cnt++; done_rel = rel; end
    if (bus.busy) begin busy_cnt++; busy_last = rel; end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic longint sat16(input longint v);
    return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
  endfunction

  function automatic logic [47:0] ref_row(input logic [47:0] w, input logic [47:0] g,
                                          input logic [15:0] lr);
    logic [47:0] res;
    for (int j = 0; j < 3; j++) begin
      logic [15:0] wl, gl;
      longint p, q, n;
      wl = w[(3-j)*16-1 -: 16];
      gl = g[(3-j)*16-1 -: 16];
      p  = longint'($signed(lr)) * longint'($signed(gl));
      q  = p / 256;
      if (p < 0 && (p % 256) != 0) q = q - 1;
      n  = sat16(longint'($signed(wl)) - sat16(q));
      res[(3-j)*16-1 -: 16] = n[15:0];
    end
    return res;
  endfunction

  function automatic logic [63:0] outs_flat();
    return {bus.busy, bus.done, bus.cal_dc_dw, bus.w_rd_en, bus.w_wr_en,
            bus.dc_dw_layer[3:0], bus.dc_dw_row[3:0], bus.w_layer[3:0], bus.w_row[3:0],
            bus.w_wr_data[34:0]} | {61'd0, |bus.w_wr_data[47:35], 2'b00};
  endfunction

  task automatic clear_logs();
    req_q.delete(); wr_q.delete();
    done_cnt = 0; done_rel = -1; busy_cnt = 0; busy_last = 0;
  endtask

  task automatic run_pass(input logic [31:0] nl, input logic [15:0] lr, input int pulse);
    int rel;
    wm0 = wmem;
    clear_logs();
    @(posedge clk); #1;
    bus.num_layers = nl; bus.learning_rate = lr; bus.start = 1;
    @(posedge clk); #1;
    t0 = cyc; bus.start = 0; mon_en = 1;
    bus.learning_rate = ~lr;
    bus.num_layers    = $urandom;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      rel = cyc - t0 + 1;
      bus.start = (rel == pulse);
      if (done_rel >= 0 && rel >= done_rel + 2) break;
    end
    bus.start = 0;
    mon_en = 0;
    if (done_rel < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic verify(input logic [31:0] nl, input logic [15:0] lr);
    int L, n;
    L = (nl > 4) ? 4 : int'(nl);
    chk("req_count", req_q.size(), 3*L);
    chk("wr_count", wr_q.size(), 3*L);
    chk("done_cycle", done_rel, 9*L + 1);
    chk("done_pulses", done_cnt, 1);
    chk("busy_cycles", busy_cnt, 9*L + 1);
    chk("busy_last", busy_last, 9*L + 1);
    n = (req_q.size() < 3*L) ? req_q.size() : 3*L;
    for (int i = 0; i < n; i++) begin
      chk("req_cycle", req_q[i].rel, 1 + 3*i);
      chk("req_addr", {req_q[i].l, req_q[i].r}, {32'(i/3), 32'(i%3)});
      chk("req_waddr", {req_q[i].wl, req_q[i].wr}, {32'(i/3), 32'(i%3)});
      chk("req_strobes", {req_q[i].cal, req_q[i].rd}, 2'b11);
    end
    n = (wr_q.size() < 3*L) ? wr_q.size() : 3*L;
    for (int i = 0; i < n; i++) begin
      chk("wr_cycle", wr_q[i].rel, 3 + 3*i);
      chk("wr_addr", {wr_q[i].l, wr_q[i].r}, {32'(i/3), 32'(i%3)});
      chk("wr_data", wr_q[i].data, ref_row(wm0[i/3][i%3], gmem[i/3][i%3], lr));
    end
  endtask

  task automatic fill_random();
    for (int l = 0; l < 4; l++)
      for (int r = 0; r < 4; r++) begin
        gmem[l][r] = {16'($urandom), 16'($urandom), 16'($urandom)};
        wmem[l][r] = {16'($urandom), 16'($urandom), 16'($urandom)};
      end
  endtask

  typedef struct { logic [15:0] lr, g, w, exp; } vec_t;
  vec_t tbl [7];

  initial begin
    tbl[0] = '{16'h0100, 16'h0100, 16'h0300, 16'h0200};
    tbl[1] = '{16'h0100, 16'h8100, 16'h7F00, 16'h7FFF};
    tbl[2] = '{16'h0100, 16'h7F00, 16'h8100, 16'h8000};
    tbl[3] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h8001};
    tbl[4] = '{16'h0080, 16'hFFFF, 16'h0000, 16'h0001};
    tbl[5] = '{16'h8000, 16'h8000, 16'h0000, 16'h8001};
    tbl[6] = '{16'h0100, 16'h0000, 16'h1234, 16'h1234};

    bus.start = 0; bus.num_layers = 0; bus.learning_rate = 0;
    fill_random();
    repeat (3) @(posedge clk);
    #1 reset = 1;
    #1 chk("reset_outputs", outs_flat(), 64'd0);

    foreach (tbl[v]) begin
      for (int l = 0; l < 4; l++)
        for (int r = 0; r < 4; r++) begin
          gmem[l][r] = {3{tbl[v].g}};
          wmem[l][r] = {3{tbl[v].w}};
        end
      run_pass(1, tbl[v].lr, 0);
      verify(1, tbl[v].lr);
      foreach (wr_q[i])
        for (int j = 0; j < 3; j++) begin
          logic [47:0] d;
          d = wr_q[i].data;
          chk("tbl_lane", d[(3-j)*16-1 -: 16], tbl[v].exp);
        end
    end

    fill_random();
    run_pass(2, 16'h0040, 0);  verify(2, 16'h0040);
    run_pass(0, 16'h0100, 0);  verify(0, 16'h0100);
    run_pass(9, 16'hFF80, 0);  verify(9, 16'hFF80);
    if (wr_q.size() > 0) chk("last_wr_addr", {wr_q[wr_q.size()-1].l, wr_q[wr_q.size()-1].r}, {32'd3, 32'd2});
    else chk("last_wr_addr", 64'hFFFF_FFFF_FFFF_FFFF, {32'd3, 32'd2});
    run_pass(2, 16'h0123, 4);  verify(2, 16'h0123);

    // asynchronous reset landing in the first CAPTURE cycle
    clear_logs();
    @(posedge clk); #1 bus.num_layers = 2; bus.learning_rate = 16'h0100; bus.start = 1;
    @(posedge clk); #1 t0 = cyc; bus.start = 0;
    @(posedge clk); #2 reset = 0;
    #1 chk("midreset_outputs", outs_flat(), 64'd0);
    mon_en = 1;
    repeat (4) @(posedge clk);
    #1 mon_en = 0;
    chk("midreset_no_write", wr_q.size(), 0);
    chk("midreset_no_done", done_cnt, 0);
    reset = 1;
    run_pass(1, 16'h0200, 0);  verify(1, 16'h0200);

    for (int p = 0; p < 8; p++) begin
      logic [31:0] nl;
      logic [15:0] lr;
      fill_random();
      nl = $urandom_range(0, 6);
      lr = (p % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h03FF));
      run_pass(nl, lr, 0);
      verify(nl, lr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
